// File: rtl/digit_serial_adder.sv
// Digit-serial wide adder: one 2-bit digit per clock through a single
// cla_4bit slice, with the digit carry fed back through a register.

module cla_4bit (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       CARRY_IN,
  output logic [1:0] SUM,
  output logic       CARRY_OUT
);

  logic [1:0] gen;
  logic [1:0] prop;
  logic       c1;

  assign gen  = A & B;
  assign prop = A ^ B;
  assign c1   = gen[0] | (prop[0] & CARRY_IN);
  assign CARRY_OUT = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & CARRY_IN);
  assign SUM  = prop ^ {c1, CARRY_IN};

endmodule

module digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM_OUT,
  output logic             COUT
);

  localparam int N    = WIDTH / 2;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [IDXW-1:0]  idx;
  logic [IDXW:0]    bit_pos;
  logic             carry_reg;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic [1:0]       slice_sum;
  logic             slice_cout;

  assign bit_pos = {idx, 1'b0};
  assign slice_a = a_reg[bit_pos +: 2];
  assign slice_b = b_reg[bit_pos +: 2];

  cla_4bit u_slice (
    .A         (slice_a),
    .B         (slice_b),
    .CARRY_IN  (carry_reg),
    .SUM       (slice_sum),
    .CARRY_OUT (slice_cout)
  );

  // Working result with the current digit merged in, so the final digit
  // reaches SUM_OUT on the same edge that finishes the add.
  always_comb begin
    work_next = work;
    work_next[bit_pos +: 2] = slice_sum;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SUM_OUT   <= '0;
      COUT      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      work      <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE, DONE_ST: begin
          if (START) begin
            a_reg     <= A_IN;
            b_reg     <= B_IN;
            carry_reg <= CIN;
            work      <= '0;
            idx       <= '0;
            BUSY      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work      <= work_next;
          carry_reg <= slice_cout;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            SUM_OUT <= work_next;
            COUT    <= slice_cout;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= DONE_ST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: a WIDTH=8 and a WIDTH=2 instance
// share one clock; drivers push expected results, monitors pop on DONE.

module tb_digit_serial_adder;

  typedef struct {
    logic [8:0] res;
    int         done_cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rst_q = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start2 = 1'b0, cin2 = 1'b0, busy2, done2, cout2;
  logic [1:0] a2 = '0, b2 = '0, sum2;

  exp_t       q8[$];
  exp_t       q2[$];
  logic [8:0] last8 = '0;
  logic [2:0] last2 = '0;

  digit_serial_adder #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(start8), .A_IN(a8), .B_IN(b8), .CIN(cin8),
    .BUSY(busy8), .DONE(done8), .SUM_OUT(sum8), .COUT(cout8)
  );

  digit_serial_adder #(.WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .START(start2), .A_IN(a2), .B_IN(b2), .CIN(cin2),
    .BUSY(busy2), .DONE(done2), .SUM_OUT(sum2), .COUT(cout2)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RST;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Issues one add on the WIDTH=8 instance; returns one cycle after acceptance.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic [8:0] res);
    exp_t e;
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    e.res = res; e.done_cyc = cyc + 5;
    q8.push_back(e);
    tick(1);
    start8 = 1'b0;
  endtask

  task automatic apply_stimulus2(input logic [1:0] a, input logic [1:0] b, input logic cin,
                                 input logic [2:0] res);
    exp_t e;
    a2 = a; b2 = b; cin2 = cin; start2 = 1'b1;
    e.res = {6'd0, res}; e.done_cyc = cyc + 2;
    q2.push_back(e);
    tick(1);
    start2 = 1'b0;
  endtask

  // Monitor for the WIDTH=8 instance.
  always @(negedge CLK) begin
    exp_t e;
    logic exp_busy;
    check_output("busy_done_excl8", 32'(busy8 & done8), 32'd0);
    if (rst_q) begin
      check_output("reset_busy8", 32'(busy8), 32'd0);
      check_output("reset_done8", 32'(done8), 32'd0);
      check_output("reset_result8", {23'd0, cout8, sum8}, 32'd0);
      last8 = '0;
    end else begin
      exp_busy = (q8.size() > 0) && (cyc >= q8[0].done_cyc - 4) && (cyc < q8[0].done_cyc);
      check_output("busy8", 32'(busy8), 32'(exp_busy));
      if (done8) begin
        if (q8.size() == 0) begin
          check_output("unexpected_done8", 32'(done8), 32'd0);
        end else begin
          e = q8.pop_front();
          check_output("done_cycle8", cyc, e.done_cyc);
          check_output("result8", {23'd0, cout8, sum8}, {23'd0, e.res});
          last8 = e.res;
        end
      end else begin
        check_output("hold8", {23'd0, cout8, sum8}, {23'd0, last8});
        if (q8.size() > 0 && cyc >= q8[0].done_cyc) begin
          check_output("missing_done8", 32'(done8), 32'd1);
          void'(q8.pop_front());
        end
      end
    end
  end

  // Monitor for the WIDTH=2 instance.
  always @(negedge CLK) begin
    exp_t e;
    logic exp_busy;
    check_output("busy_done_excl2", 32'(busy2 & done2), 32'd0);
    if (rst_q) begin
      check_output("reset_result2", {28'd0, busy2, cout2, sum2}, 32'd0);
      last2 = '0;
    end else begin
      exp_busy = (q2.size() > 0) && (cyc == q2[0].done_cyc - 1);
      check_output("busy2", 32'(busy2), 32'(exp_busy));
      if (done2) begin
        if (q2.size() == 0) begin
          check_output("unexpected_done2", 32'(done2), 32'd0);
        end else begin
          e = q2.pop_front();
          check_output("done_cycle2", cyc, e.done_cyc);
          check_output("result2", {29'd0, cout2, sum2}, {29'd0, e.res[2:0]});
          last2 = e.res[2:0];
        end
      end else begin
        check_output("hold2", {29'd0, cout2, sum2}, {29'd0, last2});
        if (q2.size() > 0 && cyc >= q2[0].done_cyc) begin
          check_output("missing_done2", 32'(done2), 32'd1);
          void'(q2.pop_front());
        end
      end
    end
  end

  initial begin
    logic [2:0] ref2;
    tick(2);
    RST = 1'b0;
    tick(1);

    // Basic adds and full-length carry ripple, each followed by an idle cycle.
    apply_stimulus(8'h12, 8'h34, 1'b0, 9'h046); tick(5);
    apply_stimulus(8'hFF, 8'h01, 1'b0, 9'h100); tick(5);
    apply_stimulus(8'hA5, 8'h5A, 1'b1, 9'h100); tick(5);
    apply_stimulus(8'h55, 8'h55, 1'b1, 9'h0AB); tick(5);
    apply_stimulus(8'h00, 8'h00, 1'b1, 9'h001); tick(5);
    apply_stimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF); tick(5);

    // START held with junk operands while running must be ignored.
    apply_stimulus(8'h10, 8'h20, 1'b0, 9'h030);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick(4);
    start8 = 1'b0;
    tick(2);

    // Back-to-back: new add accepted in the DONE cycle.
    apply_stimulus(8'h01, 8'h02, 1'b0, 9'h003); tick(4);
    apply_stimulus(8'h80, 8'h80, 1'b1, 9'h101); tick(6);

    // Reset mid-operation aborts the add.
    apply_stimulus(8'h7F, 8'h01, 1'b0, 9'h080);
    tick(1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    q8.delete();
    tick(8);
    apply_stimulus(8'h7F, 8'h01, 1'b0, 9'h080); tick(6);

    // WIDTH=2: directed case, then every operand combination back-to-back.
    apply_stimulus2(2'b11, 2'b11, 1'b1, 3'b111); tick(2);
    for (int i = 0; i < 32; i++) begin
      ref2 = 3'({1'b0, 2'(i >> 3)} + {1'b0, 2'(i >> 1)} + {2'b00, 1'(i)});
      apply_stimulus2(2'(i >> 3), 2'(i >> 1), 1'(i), ref2);
      tick(1);
    end
    tick(4);

    check_output("drained8", q8.size(), 32'd0);
    check_output("drained2", q2.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Sequential wide-operand adder built around the team's 2-bit adder cell (cla_4bit; ports A, B, CARRY_IN, SUM, CARRY_OUT), instantiated once inside this block.
- Processes WIDTH-bit operands one 2-bit digit per clock, LSB digit first.
- Carries the slice CARRY_OUT between cycles in a register.
- Sits directly upstream of the slice: it owns operand sequencing, carry feedback and result assembly.
- Gives a START/BUSY/DONE handshake to the control logic that uses it.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; N = WIDTH/2 digit cycles per add.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous active-high reset.
START  input  1  request a new add; sampled only when accepting (state IDLE or DONE_ST).
A_IN  input  WIDTH  operand A; captured on the accepting edge.
B_IN  input  WIDTH  operand B; captured on the accepting edge.
CIN  input  1  carry-in; captured on the accepting edge.
BUSY  output  1  high while digit cycles are in progress.
DONE  output  1  one-cycle pulse; result is valid.
SUM_OUT  output  WIDTH  registered sum of the last completed add.
COUT  output  1  registered carry-out of the last completed add.

Behaviour:
- Reset:
  - RST=1 at an edge forces state IDLE.
  - Clears BUSY, DONE, SUM_OUT, COUT, digit index, carry register, operand and working registers to 0.
  - RST has priority over START.
- Reset mid-operation aborts the add. No DONE is produced and SUM_OUT/COUT read 0.
- States:
  - IDLE: BUSY=0, DONE=0. START=1 -> latch A_IN, B_IN into operand regs; carry_reg<=CIN; idx<=0; go RUN.
  - RUN: BUSY=1, DONE=0. Slice inputs are A_reg[2idx+1:2idx], B_reg[2idx+1:2idx], carry_reg. Each edge:
    - work[2idx+1:2idx] <= slice SUM.
    - carry_reg <= slice CARRY_OUT.
    - idx <= idx+1.
    - When idx = N-1: SUM_OUT <= completed work (including the final digit), COUT <= slice CARRY_OUT, go DONE_ST.
  - DONE_ST: BUSY=0, DONE=1 for exactly this cycle. START=1 -> accept new operands exactly as in IDLE and go RUN. Otherwise go IDLE.
- Latency: START high in cycle 0 (accepting state) -> BUSY high in cycles 1..N -> DONE high in cycle N+1. Back-to-back adds therefore occur every N+1 cycles.
- START during RUN is ignored: no capture and no effect on the current add.
- A_IN, B_IN and CIN are don't-care except on the accepting edge.
- SUM_OUT/COUT change only on the edge entering DONE_ST, or on reset. They hold the previous result through RUN and IDLE, and partial sums are never visible.
- Arithmetic: {COUT, SUM_OUT} = A + B + CIN, modulo 2^(WIDTH+1), exact. Carry wraps from digit to digit only through carry_reg.
- idx width is ceil(log2(N)), minimum 1 bit. With WIDTH=2 (N=1) the block spends one RUN cycle and DONE appears in cycle 2.
- BUSY and DONE are never high in the same cycle.

Test Plan:
1. WIDTH=8; A=0x12, B=0x34, CIN=0; START pulse in cycle 0 -> BUSY high cycles 1-4, DONE pulse in cycle 5, SUM_OUT=0x46, COUT=0.
2. WIDTH=8; A=0xFF, B=0x01, CIN=0 -> SUM_OUT=0x00, COUT=1. Also A=0xA5, B=0x5A, CIN=1 -> SUM_OUT=0x00, COUT=1 (full-length carry ripple across all digits).
3. Start add 0x10+0x20. Hold START=1 with A=0xFF, B=0xFF during cycles 1-4 -> ignored; DONE in cycle 5 with SUM_OUT=0x30, COUT=0.
4. Complete 0x01+0x02 (SUM_OUT=0x03). In the DONE cycle assert START with 0x80+0x80, CIN=1 -> accepted; next DONE 5 cycles later with SUM_OUT=0x01, COUT=1. SUM_OUT holds 0x03 throughout.
5. Start 0x7F+0x01; assert RST in cycle 2 -> from next cycle BUSY=0, DONE=0, SUM_OUT=0x00, COUT=0, and no DONE follows. A fresh START then completes normally.
6. WIDTH=2; A=2'b11, B=2'b11, CIN=1 -> BUSY in cycle 1 only, DONE in cycle 2, SUM_OUT=2'b11, COUT=1. Exhaust all 32 input combinations against the reference sum.
